dmem_responder: RTL and testbench

Data-memory responder on the far side of the CPU's load/store interface. It accepts the core's MemRead/MemWrite requests (address taken from ALUOut), performs byte/half/word accesses on an internal synchronous RAM, and returns load data with a MemReady handshake. The core uses MemReady to gate its PC enable. Configurable wait states let the single-cycle core be exercised against slow memory.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_lane_align.sv | 55 +++++
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and FSM state type for the data-memory responder
package dmem_pkg;

  // Access size/sign encodings carried on funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Memory-mapped register window (only decoded when DMEM_MMIO_EN is defined)
  localparam logic [3:0]  MMIO_REGION   = 4'hF;
  localparam logic [31:0] MMIO_LED_ADDR = 32'hF000_0000;
  localparam logic [31:0] MMIO_CYC_ADDR = 32'hF000_0004;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store byte-lane steering, load extraction/extension, access error flag
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        access_err
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte/half of the RAM word, then size-decode the access
  always_comb begin
    case (addr_lo)
      2'd0:    sel_byte = load_word[7:0];
      2'd1:    sel_byte = load_word[15:8];
      2'd2:    sel_byte = load_word[23:16];
      default: sel_byte = load_word[31:24];
    endcase
    sel_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

    byte_en    = 4'b0000;
    store_word = 32'h0;
    load_data  = 32'h0;
    access_err = 1'b0;

    case (funct3)
      F3_B, F3_BU: begin
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{store_data[7:0]}};
        load_data  = (funct3 == F3_B) ? {{24{sel_byte[7]}}, sel_byte} : {24'h0, sel_byte};
      end
      F3_H, F3_HU: begin
        access_err = addr_lo[0];
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_word = {2{store_data[15:0]}};
        load_data  = (funct3 == F3_H) ? {{16{sel_half[15]}}, sel_half} : {16'h0, sel_half};
      end
      F3_W: begin
        access_err = (addr_lo != 2'b00);
        byte_en    = 4'b1111;
        store_word = store_data;
        load_data  = load_word;
      end
      default: access_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with wait states; optional MMIO via DMEM_MMIO_EN
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [2:0]  funct3,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   ram_q [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [3:0]    byte_en;
  logic [31:0]   store_word;
  logic [31:0]   load_data;
  logic          lane_err;
  logic          commit;
  logic          acc_err;
  logic          ram_we;
  logic          is_mmio;
  logic          mmio_err;
  logic [31:0]   mmio_rdata;

`ifdef DMEM_MMIO_EN
  logic [31:0]   led_q, led_d;
  logic [31:0]   cyc_q, cyc_d;
`else
  // Upper address bits only alias into RAM in this build
  logic          unused_addr_hi;
  assign unused_addr_hi = ^Addr[31:AW+2];
`endif

  assign word_idx = Addr[AW+1:2];

  dmem_lane_align u_align (
    .addr_lo    (Addr[1:0]),
    .funct3     (funct3),
    .store_data (WriteData),
    .load_word  (ram_q[word_idx]),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_data  (load_data),
    .access_err (lane_err)
  );

  // Next-state, wait counter, and commit of the access on the edge entering DONE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    commit     = 1'b0;
    ram_we     = 1'b0;
    is_mmio    = 1'b0;
    mmio_err   = 1'b0;
    mmio_rdata = 32'h0;
`ifdef DMEM_MMIO_EN
    led_d      = led_q;
    cyc_d      = cyc_q + 32'd1;
    is_mmio    = (Addr[31:28] == MMIO_REGION);
    mmio_err   = !(((Addr == MMIO_LED_ADDR) || (Addr == MMIO_CYC_ADDR)) && (funct3 == F3_W));
    mmio_rdata = (Addr == MMIO_CYC_ADDR) ? cyc_q : led_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (MemRead || MemWrite) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_DONE;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    acc_err = (MemRead && MemWrite) || (is_mmio ? mmio_err : lane_err);

    if (commit) begin
      err_d = acc_err;
      if (acc_err) begin
        rdata_d = 32'h0;
      end else if (MemWrite) begin
        ram_we = !is_mmio;
`ifdef DMEM_MMIO_EN
        if (is_mmio && (Addr == MMIO_LED_ADDR)) led_d = WriteData;
`endif
      end else begin
        rdata_d = is_mmio ? mmio_rdata : load_data;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
`ifdef DMEM_MMIO_EN
      led_q   <= 32'h0;
      cyc_q   <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DMEM_MMIO_EN
      led_q   <= led_d;
      cyc_q   <= cyc_d;
`endif
    end
  end

  // RAM byte-lane write; contents survive reset, but reset on the commit edge blocks the write
  always_ff @(posedge clk) begin
    if (rst_n && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) ram_q[word_idx][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

  assign ReadData = rdata_q;
  assign MemReady = (state_q == ST_DONE);
  assign MemErr   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder
module tb_dmem_responder;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [31:0] Addr, WriteData;
  logic [2:0]  funct3;
  logic [31:0] ReadData;
  logic        MemReady, MemErr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .funct3    (funct3),
    .ReadData  (ReadData),
    .MemReady  (MemReady),
    .MemErr    (MemErr)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [2:0] f,
                            output logic [31:0] got_rd, output logic got_err, output int lat);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd; funct3 = f;
    lat = -1; got_rd = 32'h0; got_err = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (MemReady) begin
        lat = c; got_rd = ReadData; got_err = MemErr;
        break;
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    logic [31:0] got_rd;
    logic        got_err;
    int          lat;
    logic [8:0]  mask;
    logic [31:0] first_cyc;
    int          ready_seen;

    // op, op, addr, wdata, funct3, expected ReadData, expected MemErr
    vecs[0]  = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h13,   32'h00000080, 3'b000, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h13,   32'h0,        3'b000, 32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h13,   32'h0,        3'b100, 32'h00000080, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h10,   32'h0,        3'b010, 32'h80ADBEEF, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h11,   32'h0,        3'b001, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'h12,   32'h11111111, 3'b010, 32'h00000000, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h10,   32'h0,        3'b010, 32'h80ADBEEF, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h12,   32'h0000CAFE, 3'b001, 32'h80ADBEEF, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h12,   32'h0,        3'b101, 32'h0000CAFE, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h12,   32'h0,        3'b001, 32'hFFFFCAFE, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h10,   32'h0,        3'b010, 32'hCAFEBEEF, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h10,   32'h0,        3'b011, 32'h00000000, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 32'h10,   32'h00000000, 3'b010, 32'h00000000, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 32'h10,   32'h0,        3'b010, 32'hCAFEBEEF, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 32'h1010, 32'h0,        3'b010, 32'hCAFEBEEF, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 32'h20,   32'h0BADF00D, 3'b010, 32'hCAFEBEEF, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 32'h11,   32'h0,        3'b000, 32'hFFFFFFBE, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 32'h12,   32'h0,        3'b100, 32'h000000FE, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 32'h23,   32'h0,        3'b000, 32'h0000000B, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 32'h10,   32'h0,        3'b001, 32'hFFFFBEEF, 1'b0};

    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Addr = 32'h0; WriteData = 32'h0; funct3 = 3'b010;
    repeat (3) @(negedge clk);
    check("reset ReadData", ReadData, 32'h0);
    check("reset MemReady", {31'h0, MemReady}, 32'h0);
    check("reset MemErr", {31'h0, MemErr}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].f3, got_rd, got_err, lat);
      check($sformatf("vec%0d latency", i), lat, WS + 1);
      check($sformatf("vec%0d ReadData", i), got_rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d MemErr", i), {31'h0, got_err}, {31'h0, vecs[i].exp_err});
    end

    // Load held high across three back-to-back transactions
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h10; funct3 = 3'b010;
    mask = 9'h0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (MemReady) begin
        mask[c-1] = 1'b1;
        check($sformatf("held load c%0d ReadData", c), ReadData, 32'hCAFEBEEF);
      end
    end
    MemRead = 1'b0;
    check("held load pulse pattern", {23'h0, mask}, {23'h0, 9'b010010010});

    // Reset during WAIT of a store: no completion, no write, outputs cleared
    @(negedge clk);
    MemWrite = 1'b1; Addr = 32'h20; WriteData = 32'h12345678; funct3 = 3'b010;
    @(negedge clk);
    check("store in WAIT MemReady", {31'h0, MemReady}, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort ReadData", ReadData, 32'h0);
    check("abort MemReady", {31'h0, MemReady}, 32'h0);
    check("abort MemErr", {31'h0, MemErr}, 32'h0);
    MemWrite = 1'b0; rst_n = 1'b1;
    ready_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (MemReady) ready_seen++;
    end
    check("abort no late MemReady", ready_seen, 0);
    run_access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, got_rd, got_err, lat);
    check("after abort latency", lat, WS + 1);
    check("after abort LW 0x20", got_rd, 32'h0BADF00D);
    check("after abort MemErr", {31'h0, got_err}, 32'h0);

`ifdef DMEM_MMIO_EN
    run_access(1'b0, 1'b1, 32'hF000_0000, 32'h000000A5, 3'b010, got_rd, got_err, lat);
    check("mmio SW led MemErr", {31'h0, got_err}, 32'h0);
    run_access(1'b1, 1'b0, 32'hF000_0000, 32'h0, 3'b010, got_rd, got_err, lat);
    check("mmio LW led", got_rd, 32'h000000A5);
    check("mmio LW led latency", lat, WS + 1);
    run_access(1'b1, 1'b0, 32'hF000_0004, 32'h0, 3'b010, got_rd, got_err, lat);
    first_cyc = got_rd;
    check("mmio LW cyc1 MemErr", {31'h0, got_err}, 32'h0);
    run_access(1'b1, 1'b0, 32'hF000_0004, 32'h0, 3'b010, got_rd, got_err, lat);
    check("mmio cyc increasing", {31'h0, (got_rd > first_cyc)}, 32'h1);
    run_access(1'b0, 1'b1, 32'hF000_0000, 32'h0, 3'b000, got_rd, got_err, lat);
    check("mmio SB led MemErr", {31'h0, got_err}, 32'h1);
    run_access(1'b1, 1'b0, 32'hF000_0008, 32'h0, 3'b010, got_rd, got_err, lat);
    check("mmio LW unmapped MemErr", {31'h0, got_err}, 32'h1);
`else
    first_cyc = 32'h0;
    run_access(1'b1, 1'b0, 32'hF000_0010, 32'h0, 3'b010, got_rd, got_err, lat);
    check("F-region alias LW", got_rd, 32'hCAFEBEEF + first_cyc);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
